// File: rtl/mac_pkt_pkg.sv
// Shared types for the MAC packet-transmit path: word/mod widths, arbiter state
// and the per-word sideband bundle.
package mac_pkt_pkg;

  localparam int unsigned WordW = 64;
  localparam int unsigned ModW  = 3;

  typedef enum logic [0:0] {
    StIdle,
    StXfer
  } state_e;

  typedef struct packed {
    logic [WordW-1:0] data;
    logic             sop;
    logic             eop;
    logic [ModW-1:0]  mod;
  } pkt_word_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: scans req starting just after
// the last-served index and wraps around.
module rr_pick #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned GNT_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [GNT_W-1:0] last,
  output logic             found,
  output logic [GNT_W-1:0] idx
);

  always_comb begin
    int unsigned        cand;
    logic [GNT_W-1:0]   cand_idx;
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    // Walk from the farthest candidate inward so the nearest request wins.
    for (int unsigned k = N_SRC; k >= 1; k--) begin
      cand     = (32'(last) + k) % N_SRC;
      cand_idx = GNT_W'(cand);
      if (req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/pkt_tx_arbiter.sv
// Round-robin packet arbiter feeding the xge_mac pkt_tx interface: whole
// packets are granted SOP to EOP, outputs are registered, framing errors counted.
module pkt_tx_arbiter
  import mac_pkt_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned GNT_W = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk_156m25,
  input  logic                    reset_156m25_n,
  input  logic [N_SRC*WordW-1:0]  src_data,
  input  logic [N_SRC-1:0]        src_val,
  input  logic [N_SRC-1:0]        src_sop,
  input  logic [N_SRC-1:0]        src_eop,
  input  logic [N_SRC*ModW-1:0]   src_mod,
  output logic [N_SRC-1:0]        src_rdy,
  output logic [WordW-1:0]        pkt_tx_data,
  output logic                    pkt_tx_val,
  output logic                    pkt_tx_sop,
  output logic                    pkt_tx_eop,
  output logic [ModW-1:0]         pkt_tx_mod,
  input  logic                    pkt_tx_full,
  output logic [GNT_W-1:0]        gnt_id,
  output logic                    gnt_busy,
  output logic [CNT_W-1:0]        viol_cnt
);

  localparam int unsigned VW = $clog2(N_SRC + 1);

  state_e           state_q, state_d;
  logic [GNT_W-1:0] last_q, last_d;
  logic [GNT_W-1:0] gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic             first_q, first_d;
  logic             run_q;
  logic             val_q, val_d;
  pkt_word_t        out_q, out_d;
  logic [CNT_W-1:0] viol_q, viol_d;
  logic [CNT_W:0]   viol_sum;
  logic [VW-1:0]    n_viol;

  pkt_word_t        src_word [N_SRC];
  pkt_word_t        cur;
  logic [N_SRC-1:0] headless, sop_req, rdy;
  logic             found;
  logic [GNT_W-1:0] pick;

  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      src_word[i].data = src_data[WordW*i +: WordW];
      src_word[i].sop  = src_sop[i];
      src_word[i].eop  = src_eop[i];
      src_word[i].mod  = src_mod[ModW*i +: ModW];
    end
  end

  // run_q keeps src_rdy low while reset is asserted and for the release cycle.
  assign headless = (run_q && state_q == StIdle) ? (src_val & ~src_sop) : '0;
  assign sop_req  = (run_q && state_q == StIdle) ? (src_val &  src_sop) : '0;

  rr_pick #(
    .N_SRC (N_SRC),
    .GNT_W (GNT_W)
  ) u_rr_pick (
    .req   (sop_req),
    .last  (last_q),
    .found (found),
    .idx   (pick)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    first_d   = first_q;
    val_d     = 1'b0;
    out_d     = out_q;
    out_d.sop = 1'b0;
    out_d.eop = 1'b0;
    out_d.mod = '0;
    rdy       = '0;
    n_viol    = '0;
    cur       = src_word[gnt_id_q];

    unique case (state_q)
      StIdle: begin
        rdy = headless;
        for (int unsigned i = 0; i < N_SRC; i++) begin
          n_viol = n_viol + VW'(headless[i]);
        end
        if (found) begin
          gnt_id_d = pick;
          busy_d   = 1'b1;
          first_d  = 1'b1;
          state_d  = StXfer;
        end
      end
      StXfer: begin
        rdy[gnt_id_q] = ~pkt_tx_full;
        if (src_val[gnt_id_q] && !pkt_tx_full) begin
          val_d      = 1'b1;
          out_d.data = cur.data;
          out_d.sop  = cur.sop & first_q;
          out_d.eop  = cur.eop;
          out_d.mod  = cur.eop ? cur.mod : '0;
          first_d    = 1'b0;
          // A repeated SOP inside a packet is passed on as data and flagged.
          if (cur.sop && !first_q) n_viol = VW'(1'b1);
          if (cur.eop) begin
            last_d  = gnt_id_q;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    viol_sum = {1'b0, viol_q} + {{(CNT_W + 1 - VW){1'b0}}, n_viol};
    viol_d   = viol_sum[CNT_W] ? '1 : viol_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q  <= StIdle;
      last_q   <= GNT_W'(N_SRC - 1);
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      first_q  <= 1'b0;
      run_q    <= 1'b0;
      val_q    <= 1'b0;
      out_q    <= '0;
      viol_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      first_q  <= first_d;
      run_q    <= 1'b1;
      val_q    <= val_d;
      out_q    <= out_d;
      viol_q   <= viol_d;
    end
  end

  assign src_rdy     = rdy;
  assign pkt_tx_data = out_q.data;
  assign pkt_tx_val  = val_q;
  assign pkt_tx_sop  = out_q.sop;
  assign pkt_tx_eop  = out_q.eop;
  assign pkt_tx_mod  = out_q.mod;
  assign gnt_id      = gnt_id_q;
  assign gnt_busy    = busy_q;
  assign viol_cnt    = viol_q;

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Directed bench for pkt_tx_arbiter: per-source word queues feed the DUT and a
// negedge monitor records every word presented to the MAC.
module tb_pkt_tx_arbiter;
  import mac_pkt_pkg::*;

  localparam int unsigned NSrc = 4;
  localparam int unsigned GntW = 2;
  localparam int unsigned CntW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NSrc*64-1:0] src_data;
  logic [NSrc-1:0]   src_val, src_sop, src_eop, src_rdy;
  logic [NSrc*3-1:0] src_mod;
  logic [63:0]       pkt_tx_data;
  logic              pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_full;
  logic [2:0]        pkt_tx_mod;
  logic [GntW-1:0]   gnt_id;
  logic              gnt_busy;
  logic [CntW-1:0]   viol_cnt;

  pkt_tx_arbiter #(
    .N_SRC (NSrc),
    .GNT_W (GntW),
    .CNT_W (CntW)
  ) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .src_data       (src_data),
    .src_val        (src_val),
    .src_sop        (src_sop),
    .src_eop        (src_eop),
    .src_mod        (src_mod),
    .src_rdy        (src_rdy),
    .pkt_tx_data    (pkt_tx_data),
    .pkt_tx_val     (pkt_tx_val),
    .pkt_tx_sop     (pkt_tx_sop),
    .pkt_tx_eop     (pkt_tx_eop),
    .pkt_tx_mod     (pkt_tx_mod),
    .pkt_tx_full    (pkt_tx_full),
    .gnt_id         (gnt_id),
    .gnt_busy       (gnt_busy),
    .viol_cnt       (viol_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  pkt_word_t mem [NSrc][32];
  int        head [NSrc];
  int        tail [NSrc];
  logic [NSrc-1:0] fire = '0;

  pkt_word_t out_w    [256];
  int        out_cyc  [256];
  logic      out_busy [256];
  int        out_n = 0;

  function automatic pkt_word_t mkw(logic [63:0] d, logic s, logic e, logic [2:0] m);
    pkt_word_t w;
    w.data = d;
    w.sop  = s;
    w.eop  = e;
    w.mod  = m;
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_word(input string tag, input int idx, input pkt_word_t exp);
    check({tag, "_data"}, out_w[idx].data, exp.data);
    check({tag, "_ctl"}, {out_w[idx].sop, out_w[idx].eop, out_w[idx].mod},
          {exp.sop, exp.eop, exp.mod});
  endtask

  task automatic drive();
    for (int i = 0; i < int'(NSrc); i++) begin
      if (head[i] < tail[i]) begin
        src_val[i]          = 1'b1;
        src_sop[i]          = mem[i][head[i]].sop;
        src_eop[i]          = mem[i][head[i]].eop;
        src_data[64*i +: 64] = mem[i][head[i]].data;
        src_mod[3*i +: 3]   = mem[i][head[i]].mod;
      end else begin
        src_val[i]          = 1'b0;
        src_sop[i]          = 1'b0;
        src_eop[i]          = 1'b0;
        src_data[64*i +: 64] = '0;
        src_mod[3*i +: 3]   = '0;
      end
    end
  endtask

  task automatic load(input int s, input pkt_word_t w);
    mem[s][tail[s]] = w;
    tail[s]++;
    drive();
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < int'(NSrc); i++) if (head[i] < tail[i]) p = 1'b1;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fire  = '0;
    for (int i = 0; i < int'(NSrc); i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (!pending() && !gnt_busy) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, done, 1);
    step();
    step();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are sampled mid-cycle and retired just after the next edge.
  always @(negedge clk) begin
    fire = src_val & src_rdy;
    if (pkt_tx_val) begin
      out_w[out_n]    = mkw(pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod);
      out_cyc[out_n]  = cyc;
      out_busy[out_n] = gnt_busy;
      out_n++;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < int'(NSrc); i++) if (fire[i]) head[i]++;
    fire = '0;
    drive();
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int l;
    pkt_tx_full = 1'b0;
    for (int i = 0; i < int'(NSrc); i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive();

    // 1: three-word packet from source 0
    do_reset();
    check("t0_reset_viol", viol_cnt, 0);
    check("t0_reset_id", gnt_id, 0);
    b = out_n;
    load(0, mkw(64'hA0A0_0000_0000_0000, 1'b1, 1'b0, 3'd6));
    load(0, mkw(64'hA0A0_0000_0000_0001, 1'b0, 1'b0, 3'd6));
    load(0, mkw(64'hA0A0_0000_0000_0002, 1'b0, 1'b1, 3'd5));
    l = cyc;
    @(negedge clk);
    check("t1_idle_rdy", src_rdy, 4'b0000);
    check("t1_idle_busy", gnt_busy, 0);
    step();
    @(negedge clk);
    check("t1_grant_busy", gnt_busy, 1);
    check("t1_grant_id", gnt_id, 0);
    check("t1_grant_rdy", src_rdy, 4'b0001);
    check("t1_grant_val", pkt_tx_val, 0);
    wait_idle("t1_done");
    check("t1_count", out_n - b, 3);
    chk_word("t1_w0", b,     mkw(64'hA0A0_0000_0000_0000, 1'b1, 1'b0, 3'd0));
    chk_word("t1_w1", b + 1, mkw(64'hA0A0_0000_0000_0001, 1'b0, 1'b0, 3'd0));
    chk_word("t1_w2", b + 2, mkw(64'hA0A0_0000_0000_0002, 1'b0, 1'b1, 3'd5));
    check("t1_cyc_w0", out_cyc[b], l + 2);
    check("t1_cyc_w2", out_cyc[b + 2], l + 4);
    check("t1_busy_w1", out_busy[b + 1], 1);
    check("t1_busy_w2", out_busy[b + 2], 0);

    // 2: all sources hold two 2-word packets
    do_reset();
    b = out_n;
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 4; s++) begin
        load(s, mkw(64'hB000_0000_0000_0000 + 64'(s * 256 + p * 16), 1'b1, 1'b0, 3'd7));
        load(s, mkw(64'hB000_0000_0000_0001 + 64'(s * 256 + p * 16), 1'b0, 1'b1, 3'(s + 1)));
      end
    end
    wait_idle("t2_done");
    check("t2_count", out_n - b, 16);
    for (int j = 0; j < 8; j++) begin
      int s;
      int p;
      s = j % 4;
      p = j / 4;
      chk_word($sformatf("t2_p%0d_w0", j), b + 2 * j,
               mkw(64'hB000_0000_0000_0000 + 64'(s * 256 + p * 16), 1'b1, 1'b0, 3'd0));
      chk_word($sformatf("t2_p%0d_w1", j), b + 2 * j + 1,
               mkw(64'hB000_0000_0000_0001 + 64'(s * 256 + p * 16), 1'b0, 1'b1, 3'(s + 1)));
      check($sformatf("t2_p%0d_back2back", j), out_cyc[b + 2 * j + 1] - out_cyc[b + 2 * j], 1);
      if (j > 0)
        check($sformatf("t2_p%0d_gap", j), out_cyc[b + 2 * j] - out_cyc[b + 2 * j - 1], 2);
    end

    // 3: backpressure in the middle of a source 1 packet
    b = out_n;
    for (int k = 0; k < 6; k++)
      load(1, mkw(64'hC300_0000_0000_0000 + 64'(k), k == 0, k == 5, (k == 5) ? 3'd2 : 3'd0));
    for (int k = 0; k < 50; k++) begin
      step();
      if (out_n - b >= 2) break;
    end
    check("t3_started", out_n - b >= 2, 1);
    pkt_tx_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("t3_stall_rdy%0d", k), src_rdy[1], 0);
      if (k > 0) check($sformatf("t3_stall_val%0d", k), pkt_tx_val, 0);
      step();
    end
    pkt_tx_full = 1'b0;
    wait_idle("t3_done");
    check("t3_count", out_n - b, 6);
    for (int k = 0; k < 6; k++)
      chk_word($sformatf("t3_w%0d", k), b + k,
               mkw(64'hC300_0000_0000_0000 + 64'(k), k == 0, k == 5, (k == 5) ? 3'd2 : 3'd0));

    // 4: headless words from source 2 are dropped and counted
    b = out_n;
    for (int k = 0; k < 3; k++) load(2, mkw(64'hDEAD_0000_0000_0000 + 64'(k), 1'b0, 1'b0, 3'd1));
    load(2, mkw(64'hD400_0000_0000_0000, 1'b1, 1'b0, 3'd0));
    load(2, mkw(64'hD400_0000_0000_0001, 1'b0, 1'b1, 3'd3));
    @(negedge clk);
    check("t4_discard_rdy", src_rdy, 4'b0100);
    check("t4_discard_busy", gnt_busy, 0);
    wait_idle("t4_done");
    check("t4_viol", viol_cnt, 3);
    check("t4_count", out_n - b, 2);
    chk_word("t4_w0", b,     mkw(64'hD400_0000_0000_0000, 1'b1, 1'b0, 3'd0));
    chk_word("t4_w1", b + 1, mkw(64'hD400_0000_0000_0001, 1'b0, 1'b1, 3'd3));

    // 5: repeated SOP inside a source 3 packet
    b = out_n;
    load(3, mkw(64'hE300_0000_0000_0000, 1'b1, 1'b0, 3'd0));
    load(3, mkw(64'hE300_0000_0000_0001, 1'b1, 1'b0, 3'd0));
    load(3, mkw(64'hE300_0000_0000_0002, 1'b0, 1'b1, 3'd4));
    wait_idle("t5_done");
    check("t5_count", out_n - b, 3);
    chk_word("t5_w0", b,     mkw(64'hE300_0000_0000_0000, 1'b1, 1'b0, 3'd0));
    chk_word("t5_w1", b + 1, mkw(64'hE300_0000_0000_0001, 1'b0, 1'b0, 3'd0));
    chk_word("t5_w2", b + 2, mkw(64'hE300_0000_0000_0002, 1'b0, 1'b1, 3'd4));
    check("t5_viol", viol_cnt, 4);

    // 6: single-word packet, then reset in the middle of the next packet
    b = out_n;
    load(0, mkw(64'hF00D_0000_0000_0000, 1'b1, 1'b1, 3'd0));
    for (int k = 0; k < 4; k++)
      load(1, mkw(64'hF100_0000_0000_0000 + 64'(k), k == 0, k == 3, 3'd0));
    for (int k = 0; k < 50; k++) begin
      step();
      if (out_n - b >= 2) break;
    end
    chk_word("t6_single", b, mkw(64'hF00D_0000_0000_0000, 1'b1, 1'b1, 3'd0));
    chk_word("t6_next_w0", b + 1, mkw(64'hF100_0000_0000_0000, 1'b1, 1'b0, 3'd0));
    check("t6_mid_busy", gnt_busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_val", pkt_tx_val, 0);
    check("t6_rst_sop", pkt_tx_sop, 0);
    check("t6_rst_eop", pkt_tx_eop, 0);
    check("t6_rst_mod", pkt_tx_mod, 0);
    check("t6_rst_data", pkt_tx_data, 0);
    check("t6_rst_rdy", src_rdy, 4'b0000);
    check("t6_rst_id", gnt_id, 0);
    check("t6_rst_busy", gnt_busy, 0);
    check("t6_rst_viol", viol_cnt, 0);
    do_reset();
    load(3, mkw(64'hF300_0000_0000_0000, 1'b1, 1'b1, 3'd1));
    load(1, mkw(64'hF110_0000_0000_0000, 1'b1, 1'b1, 3'd1));
    load(0, mkw(64'hF000_0000_0000_0000, 1'b1, 1'b1, 3'd1));
    step();
    @(negedge clk);
    check("t6_first_busy", gnt_busy, 1);
    check("t6_first_id", gnt_id, 0);
    wait_idle("t6_done");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
